// File: rtl/comparador_serial_ctrl_pkg.sv
// Shared types for the bit-serial A <= B comparator: FSM state encoding and
// the counter-width helper.
package cmp_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ceil(log2(v)), but never less than 1 so a counter always has a bit
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/celda_cmp.sv
// One iterative cell of the A <= B comparator chain; z_out is the carry
// passed toward the next (more significant) bit.
module celda_cmp (
  input  logic a,
  input  logic b,
  input  logic z_in,
  output logic z_out
);

  assign z_out = (~a & b) | (~(a ^ b) & z_in);

endmodule

// File: rtl/comparador_serial_ctrl.sv
// Bit-serial A <= B comparator: one shared cell, one bit pair per clock.
// Default is LSB first with fixed latency; define CMP_MSB_FIRST_EN for
// MSB-first processing with early exit on the first differing bit.
module comparador_serial_ctrl
  import cmp_serial_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         Zout
);

  localparam int unsigned       CNT_W    = clog2_min1(N);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

  state_t           state, state_d;
  logic [N-1:0]     sa, sb;
  logic [CNT_W-1:0] cnt;
  logic             zout_q;
  logic             a_i, b_i, z_in, z_next, last, accept;

`ifdef CMP_MSB_FIRST_EN
  assign a_i  = sa[N-1];
  assign b_i  = sb[N-1];
  // With z_in tied high the cell yields b_i on a mismatch and 1 on a match,
  // which is exactly the MSB-first result at the exit bit.
  assign z_in = 1'b1;
  assign last = (a_i != b_i) || (cnt == CNT_LAST);
`else
  logic z;
  assign a_i  = sa[0];
  assign b_i  = sb[0];
  assign z_in = z;
  assign last = (cnt == CNT_LAST);
`endif

  celda_cmp u_celda (
    .a     (a_i),
    .b     (b_i),
    .z_in  (z_in),
    .z_out (z_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        accept  = start;
        state_d = start ? ST_RUN : ST_IDLE;
      end
      ST_RUN:  if (last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      zout_q <= 1'b0;
`ifndef CMP_MSB_FIRST_EN
      z      <= 1'b1;
`endif
    end else if (accept) begin
      sa     <= A;
      sb     <= B;
      cnt    <= '0;
`ifndef CMP_MSB_FIRST_EN
      z      <= 1'b1;
`endif
    end else if (state == ST_RUN) begin
`ifdef CMP_MSB_FIRST_EN
      sa <= sa << 1;
      sb <= sb << 1;
`else
      sa <= sa >> 1;
      sb <= sb >> 1;
      z  <= z_next;
`endif
      // counter holds on the final edge so it never wraps past N-1
      if (!last) cnt <= cnt + 1'b1;
      if (last)  zout_q <= z_next;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign Zout = zout_q;

endmodule

// File: doc/comparador_serial_ctrl.md
Name: comparador_serial_ctrl

Overview:
- Bit-serial sequencer for the A <= B comparator. One shared 1-bit iterative cell replaces the N-cell combinational chain.
- Captures A/B on a start handshake, then feeds one bit pair per clock, LSB first (right-to-left).
- Holds the cell's carry state between cycles and reports Zout (1 when A <= B) with a done pulse.
- Used wherever area matters more than latency; drop-in functional equivalent of the combinational network.

Parameters:
- N, 3: word width of A and B. Legal range N >= 1.
- CNT_W, $clog2(N) with a minimum of 1: width of the bit-index counter. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a comparison. Sampled only in IDLE or DONE.
- A  in  N  operand A. Captured on the accepting edge.
- B  in  N  operand B. Captured on the accepting edge.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; Zout is valid from this cycle on.
- Zout  out  1  comparison result: 1 if A <= B, 0 if A > B. Held until the next accepted start.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; busy=0, done=0, Zout=0.
  - Shift registers and counter cleared; carry z=1.
  - rst has priority over every other input.
  - Reset mid-RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE. Binary encoding, defined in the package.
- IDLE:
  - start=1 -> capture A into sa and B into sb; z=1, cnt=0; go to RUN.
  - start=0 -> stay in IDLE.
- RUN, one edge per bit i = cnt:
  - Cell function: z_next = (~a_i & b_i) | (~(a_i ^ b_i) & z). The LSB-first rule: higher bits override lower ones.
  - sa and sb shift right by 1; cnt increments.
  - When cnt == N-1 on this edge: Zout = z_next; go to DONE.
  - start is ignored in RUN. A/B changes are ignored after capture.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - start=1 -> accepted as in IDLE (back-to-back operation); go to RUN.
  - Otherwise go to IDLE.
- Latency: start accepted at edge t0 -> done=1 in the cycle after edge t0+N.
  - Back-to-back throughput: one result per N+1 cycles.
- N=1: RUN lasts one edge; cnt never exceeds 0; no wrap.
- Equal operands give z=1 throughout, so Zout=1.
- Zout changes only on the final RUN edge or on reset.

Optional Feature:
- Macro: CMP_MSB_FIRST_EN.
- Defined:
  - Bits are processed MSB first (left-to-right); shift registers shift left.
  - Early exit on the first bit where a_i != b_i: Zout = b_i, go to DONE immediately.
  - If all bits are equal, Zout=1 after N RUN edges.
  - Latency is variable, 1..N RUN edges plus the DONE cycle.
- Undefined: LSB-first, fixed latency as described above. Carry z is used only in this mode.

Decomposition:
- Package cmp_serial_pkg:
  - State localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Function clog2_min1 for CNT_W.
- Sub-module celda_cmp:
  - Combinational 1-bit cell with ports a, b, z_in, z_out.
  - Implements the cell equation above.
  - Instantiated once; also reusable by the combinational networks.
- Controller RTL contains the FSM, counter, two shift registers, the z flop and the Zout flop.

Test Plan (N=3 unless stated):
- Reset then idle, start=0 for 10 cycles -> busy=0, done=0, Zout=0 throughout.
- A=101, B=110, pulse start -> busy high for 3 cycles, done pulse in the 4th cycle after the accepting edge, Zout=1. Then A=111, B=000 -> Zout=0.
- Exhaustive: all 64 A/B pairs in back-to-back mode, start held high -> done every 4 cycles, Zout == (A<=B) each time.
- start pulsed again during RUN, and A/B changed mid-RUN -> no restart, result from the originally captured A=011, B=011, Zout=1.
- rst asserted on the 2nd RUN cycle -> next cycle IDLE, busy=0, Zout=0, no done. A following start completes normally.
- CMP_MSB_FIRST_EN defined, A=100, B=011 -> done after 1 RUN edge, Zout=0. A=010, B=011 -> 3 RUN edges, Zout=1. N=1 build: A=1, B=0 -> Zout=0.
